// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV engine: radix-2 shift-add multiply, restoring divide, sign fix-up.
// Define MULDIV_UNSIGNED_EN to let op[1] select MULTU/DIVU.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // |multiplicand| or |divisor|
  logic [WIDTH-1:0] wh_q, wh_d;       // partial product hi / remainder
  logic [WIDTH-1:0] wl_q, wl_d;       // multiplier bits / quotient bits
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d;

  logic             is_signed, div_zero, ge;
  logic [WIDTH-1:0] mag_a, mag_b, dsub, fix_hi, fix_lo;
  logic [WIDTH:0]   madd, dshift;
  logic [2*WIDTH-1:0] prod_neg;

`ifdef MULDIV_UNSIGNED_EN
  assign is_signed = ~op[1];
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign is_signed  = 1'b1;
`endif

  // iteration and fix-up arithmetic
  always_comb begin
    div_zero = op[0] && (srcB == '0);
    mag_a    = (is_signed && srcA[WIDTH-1]) ? -srcA : srcA;
    mag_b    = (is_signed && srcB[WIDTH-1]) ? -srcB : srcB;
    madd     = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : '0);
    dshift   = {wh_q, wl_q[WIDTH-1]};
    ge       = dshift >= {1'b0, opnd_q};
    // difference fits WIDTH bits whenever ge holds
    dsub     = dshift[WIDTH-1:0] - opnd_q;
    prod_neg = -{wh_q, wl_q};
    if (is_div_q) begin
      fix_lo = neg_res_q ? -wl_q : wl_q;
      fix_hi = neg_rem_q ? -wh_q : wh_q;
    end else if (neg_res_q) begin
      {fix_hi, fix_lo} = prod_neg;
    end else begin
      {fix_hi, fix_lo} = {wh_q, wl_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = div_zero ? DONE : CALC;
      CALC:    if (flush) state_d = IDLE;
               else if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = flush ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    hi      = hi_q;
    lo      = lo_q;
    divZero = dz_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    wh_d      = wh_q;
    wl_d      = wl_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: if (start) begin
        dz_d = div_zero;
        if (div_zero) begin
          hi_d = srcA;
          lo_d = '1;
        end else begin
          cnt_d     = '0;
          is_div_d  = op[0];
          neg_res_d = is_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
          neg_rem_d = is_signed && srcA[WIDTH-1];
          wh_d      = '0;
          opnd_d    = op[0] ? mag_b : mag_a;
          wl_d      = op[0] ? mag_a : mag_b;
        end
      end
      CALC: if (!flush) begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          wh_d = ge ? dsub : dshift[WIDTH-1:0];
          wl_d = {wl_q[WIDTH-2:0], ge};
        end else begin
          wh_d = madd[WIDTH:1];
          wl_d = {madd[0], wl_q[WIDTH-1:1]};
        end
      end
      FIX: if (!flush) begin
        hi_d = fix_hi;
        lo_d = fix_lo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      opnd_q    <= '0;
      wh_q      <= '0;
      wl_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      wh_q      <= wh_d;
      wl_q      <= wl_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] srcA, srcB, hi, lo;
  logic         busy, done, divZero;

  int total = 0, bad = 0, done_cnt = 0;
  logic [W-1:0] prev_hi = '0, prev_lo = '0;
  logic         prev_dz = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .divZero(divZero)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // returns {divZero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic uns;
    longint sa, sb, q, r;
    logic [63:0] p;
    uns = UNS_EN && o[1];
    sa  = uns ? longint'({32'b0, a}) : longint'($signed(a));
    sb  = uns ? longint'({32'b0, b}) : longint'($signed(b));
    if (!o[0]) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int ign_at, input bit fls);
    logic [64:0] e;
    int nb, lat, d0, exp_lat;
    e = model(o, a, b);
    exp_lat = e[64] ? 1 : W + 2;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; op = o; srcA = a; srcB = b; flush = fls;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    nb = 0; lat = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 1 && !done) begin
        chk("hold_hi", hi, prev_hi);
        chk("hold_lo", lo, prev_lo);
        chk("dz_clear", divZero, 0);
      end
      if (busy) nb++;
      if (done) begin lat = c; break; end
      start = (c == ign_at);
      if (c == ign_at) begin op = 2'($urandom); srcA = $urandom; srcB = $urandom; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_cycles", nb, exp_lat);
    chk("hi", hi, e[63:32]);
    chk("lo", lo, e[31:0]);
    chk("divZero", divZero, e[64]);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("done_low", done, 0);
    #1 chk("done_count", done_cnt - d0, 1);
    prev_hi = hi; prev_lo = lo; prev_dz = divZero;
  endtask

  task automatic run_flush(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int at);
    int d0;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < at; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, prev_hi);
    chk("flush_lo", lo, prev_lo);
    chk("flush_dz", divZero, prev_dz);
    repeat (40) @(negedge clk);
    #1 chk("flush_no_done", done_cnt - d0, 0);
  endtask

  task automatic run_reset(input int at);
    int d0;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; op = 2'b00; srcA = 32'd1234; srcB = 32'd5678;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < at; c++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dz", divZero, 0);
    @(negedge clk); reset = 1'b1;
    repeat (40) @(negedge clk);
    #1 chk("rst_no_done", done_cnt - d0, 0);
    prev_hi = '0; prev_lo = '0; prev_dz = 1'b0;
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; srcA = '0; srcB = '0;
    #12;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_hi", hi, 0);
    chk("init_lo", lo, 0);
    chk("init_dz", divZero, 0);
    @(negedge clk); reset = 1'b1;

    run_op(2'd0, 32'd7, 32'd6, 0, 1'b0);
    chk("mul_7x6", {hi, lo}, 64'h0000_0000_0000_002A);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
    chk("mul_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'd1, 32'd100, 32'd7, 0, 1'b0);
    chk("div_100_7", {hi, lo}, {32'd2, 32'd14});
    run_op(2'd1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'd1, 32'h0000_1234, 32'd0, 0, 1'b0);
    chk("div_zero", {divZero, hi, lo}, {1'b1, 32'h1234, 32'hFFFF_FFFF});
    run_op(2'd0, 32'd3, 32'd4, 0, 1'b0);
    chk("dz_after", divZero, 0);
    run_op(2'd0, 32'd11, 32'd13, 10, 1'b0);
    chk("ign_start", lo, 32'd143);
    run_op(2'd1, 32'd99, 32'd9, 0, 1'b1);
    run_flush(2'd1, 32'd1000, 32'd3, 20);
    run_op(2'd2, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 40));
        default: ;
      endcase
      run_op(o, a, b, 0, 1'b0);
    end

    run_reset(15);
    run_op(2'd0, 32'd5, 32'hFFFF_FFFE, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide engine for the single-cycle MIPS core's MULT/DIV instructions.
- Sits between the ALU operand path (srcA/srcB) and the HI/LO special register file.
- Takes operands on a start pulse and computes over many cycles.
- Delivers a 64-bit {hi, lo} result with a one-cycle done/write strobe to the special register file.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request; sampled only in IDLE
- op  input  2  bit0: 0 = multiply, 1 = divide; bit1: unsigned select (see Optional Feature)
- srcA  input  WIDTH  multiplicand / dividend; captured on accepted start
- srcB  input  WIDTH  multiplier / divisor; captured on accepted start
- flush  input  1  synchronous abort of an in-flight operation
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; doubles as the HI/LO write strobe
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient
- divZero  output  1  set with done when divisor is 0; cleared on the next accepted start

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, divZero = 0.
  - hi = 0, lo = 0.
  - Internal counter and operand registers cleared.
  - Takes effect immediately, mid-operation included. No done is produced for the aborted operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start = 1 at a clock edge captures the operand magnitudes, the result sign, the remainder sign and op.
  - Counter set to 0; go to CALC.
  - Exception: divide with srcB = 0 goes straight to DONE.
- CALC:
  - One iteration per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide.
  - Counter increments each cycle. Go to FIX after WIDTH iterations (counter == WIDTH-1 at the edge).
- FIX:
  - Signed operations apply two's-complement negation.
  - Multiply: the full 2*WIDTH product is negated if the operand signs differ.
  - Divide: the quotient is negated if the signs differ; the remainder takes the dividend's sign (truncate toward zero).
  - Go to DONE.
- DONE:
  - hi/lo are updated on entry to DONE.
  - done = 1 for exactly this cycle; go to IDLE.
- Latency:
  - Normal operation: start edge E0, done high in the cycle after edge E0+WIDTH+1. That is 34 cycles for WIDTH = 32, and busy is high for 34 cycles.
  - Divide by zero: done in the cycle after E0, 1 cycle.
- Divide by zero result:
  - hi = dividend (srcA unchanged).
  - lo = all ones.
  - divZero = 1.
- Signed overflow (most-negative / -1): lo = most-negative value (0x80000000), hi = 0. No flag.
- Start is ignored while busy = 1; there is no queueing.
- flush = 1 while busy:
  - Next edge returns to IDLE.
  - hi, lo and divZero keep their previous values; done is not asserted.
  - flush in IDLE has no effect.
  - flush takes priority over the state transition.
- start and flush together in IDLE: start is accepted.
- hi and lo hold their value between operations; they change only on entry to DONE or on reset.

Optional Feature:
- Macro: MULDIV_UNSIGNED_EN.
- Defined: op[1] = 1 selects MULTU/DIVU.
  - Operands are treated as unsigned and FIX applies no negation.
  - Latency is unchanged.
  - Divide by zero behaves identically.
- Undefined: op[1] is ignored and every operation is signed. The unsigned select logic is not synthesised.

Test Plan:
- Reset release, start=1, op=0, srcA=7, srcB=6 -> busy for 34 cycles; done pulses once in cycle 34; hi=0x00000000, lo=0x0000002A.
- op=0, srcA=0xFFFFFFFD (-3), srcB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then op=1, srcA=100, srcB=7 -> lo=14, hi=2.
- op=1, srcA=-7 (0xFFFFFFF9), srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then srcA=0x80000000, srcB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- op=1, srcA=0x1234, srcB=0 -> done one cycle after start; divZero=1, hi=0x1234, lo=0xFFFFFFFF. Then a following valid start -> divZero returns to 0.
- Start while busy (cycle 10) with different operands -> ignored; first result delivered; single done pulse. Then flush at cycle 20 of a new operation -> busy drops next cycle, no done, hi/lo unchanged.
- Reset pulled low at cycle 15 of a multiply -> busy/done/hi/lo = 0 immediately (asynchronous). With MULDIV_UNSIGNED_EN defined: op=2, srcA=0xFFFFFFFF, srcB=2 -> hi=1, lo=0xFFFFFFFE.
